// File: rtl/interrupt_controller_if.sv
// Bus and core-side signals for interrupt_controller; slave = controller, master = bus/core driver.
// Writes act at the next edge, reads return on the next edge, and int_req holds until int_ack.
interface interrupt_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  int_req;
    logic [DATA_WIDTH-1:0] int_pc;
    logic [2:0]            int_id;
    logic                  int_ack;
    logic                  int_done;

    modport slave (
        input  we, re, addr, data, int_ack, int_done,
        output rdata, int_req, int_pc, int_id
    );

    modport master (
        output we, re, addr, data, int_ack, int_done,
        input  rdata, int_req, int_pc, int_id
    );
endinterface

// File: rtl/interrupt_controller.sv
// Masked, lowest-index-first interrupt sequencer behind memory-mapped registers; request one edge after eligibility.
// int_req is held with stable pc/id until int_ack; no new request is issued until int_done.
module interrupt_controller #(
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    NUM_SRC          = 4,
    parameter logic [DATA_WIDTH-1:0] INT_CTRL_ADDR    = 32'h90000040,
    parameter logic [DATA_WIDTH-1:0] INT_ENABLE_ADDR  = 32'h90000044,
    parameter logic [DATA_WIDTH-1:0] INT_PENDING_ADDR = 32'h90000048,
    parameter logic [DATA_WIDTH-1:0] INT_SWI_ADDR     = 32'h9000004C,
    parameter logic [DATA_WIDTH-1:0] INT_VEC_BASE     = 32'h90000050
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       irq_in,
    interrupt_controller_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                state_q, state_d;
    logic                  ctrl_en_q;
    logic [NUM_SRC-1:0]    enable_q;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    irq_prev_q;
    logic [DATA_WIDTH-1:0] vec_q [NUM_SRC];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] int_pc_q, int_pc_d;
    logic [2:0]            sel_q, sel_d;

    logic                  wr_ctrl, wr_enable, wr_pending, wr_swi;
    logic [NUM_SRC-1:0]    vec_hit, vec_wr;
    logic [NUM_SRC-1:0]    eligible, set_mask, clr_mask, ack_mask;
    logic                  any_elig, ack_clr;
    logic [2:0]            win_id;
    logic [DATA_WIDTH-1:0] win_pc;

    assign wr_ctrl    = bus.we && (bus.addr == INT_CTRL_ADDR);
    assign wr_enable  = bus.we && (bus.addr == INT_ENABLE_ADDR);
    assign wr_pending = bus.we && (bus.addr == INT_PENDING_ADDR);
    assign wr_swi     = bus.we && (bus.addr == INT_SWI_ADDR);

    always_comb begin
        vec_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            vec_hit[i] = (bus.addr == INT_VEC_BASE + DATA_WIDTH'(4 * i));
        end
        vec_wr = vec_hit & {NUM_SRC{bus.we}};
    end

    assign eligible = ctrl_en_q ? (pending_q & enable_q) : '0;

    // Scan downward so the lowest eligible index is the last one assigned.
    always_comb begin
        any_elig = 1'b0;
        win_id   = '0;
        win_pc   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_elig = 1'b1;
                win_id   = 3'(i);
                win_pc   = vec_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        int_pc_d = int_pc_q;
        ack_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    sel_d    = win_id;
                    int_pc_d = win_pc;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    ack_clr = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.int_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // New edges and software sets override any clear landing in the same cycle.
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_mask[i] = ack_clr && (sel_q == 3'(i));
        end
        set_mask  = (irq_in & ~irq_prev_q) | (wr_swi ? bus.data[NUM_SRC-1:0] : '0);
        clr_mask  = (wr_pending ? bus.data[NUM_SRC-1:0] : '0) | ack_mask;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.re) begin
            rdata_d = '0;
            if (bus.addr == INT_CTRL_ADDR)    rdata_d = DATA_WIDTH'(ctrl_en_q);
            if (bus.addr == INT_ENABLE_ADDR)  rdata_d = DATA_WIDTH'(enable_q);
            if (bus.addr == INT_PENDING_ADDR) rdata_d = DATA_WIDTH'(pending_q);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (vec_hit[i]) rdata_d = vec_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_en_q  <= 1'b0;
            enable_q   <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
            rdata_q    <= '0;
            int_pc_q   <= '0;
            sel_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) vec_q[i] <= '0;
        end else begin
            if (wr_ctrl)   ctrl_en_q <= bus.data[0];
            if (wr_enable) enable_q  <= bus.data[NUM_SRC-1:0];
            pending_q  <= pending_d;
            irq_prev_q <= irq_in;
            rdata_q    <= rdata_d;
            int_pc_q   <= int_pc_d;
            sel_q      <= sel_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (vec_wr[i]) vec_q[i] <= bus.data;
            end
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.int_req = (state_q == REQ);
    assign bus.int_pc  = int_pc_q;
    assign bus.int_id  = sel_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic for interrupt_controller, checked against a
// cycle-level behavioural model of the registers and the one-at-a-time request sequencing.
module tb_interrupt_controller;
    localparam int          N      = 4;
    localparam int          DW     = 32;
    localparam logic [31:0] A_CTRL = 32'h90000040;
    localparam logic [31:0] A_EN   = 32'h90000044;
    localparam logic [31:0] A_PEND = 32'h90000048;
    localparam logic [31:0] A_SWI  = 32'h9000004C;
    localparam logic [31:0] A_VEC  = 32'h90000050;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;

    interrupt_controller_if #(.DATA_WIDTH(DW)) bus ();

    interrupt_controller #(.DATA_WIDTH(DW), .NUM_SRC(N)) dut (
        .clock (clock),
        .reset (reset),
        .irq_in(irq_in),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit           m_ctrl;
    logic [N-1:0] m_en, m_pend, m_prev;
    logic [31:0]  m_vec [N];
    logic [31:0]  m_rdata, m_pc;
    bit           m_req, m_busy;
    int           m_id;

    function automatic logic [31:0] reg_value(input logic [31:0] a);
        if (a == A_CTRL) return 32'(m_ctrl);
        if (a == A_EN)   return 32'(m_en);
        if (a == A_PEND) return 32'(m_pend);
        for (int i = 0; i < N; i++) if (a == A_VEC + 32'(4 * i)) return m_vec[i];
        return 32'h0;
    endfunction

    task automatic model_step();
        logic [N-1:0] set_m, clr_m, elig, low;
        logic [31:0]  a, d;
        a = bus.addr;
        d = bus.data;
        if (reset) begin
            m_ctrl = 0; m_en = '0; m_pend = '0; m_prev = '0; m_rdata = '0;
            m_req = 0; m_busy = 0; m_id = 0; m_pc = '0;
            for (int i = 0; i < N; i++) m_vec[i] = '0;
            return;
        end
        if (bus.re) m_rdata = reg_value(a);
        set_m = irq_in & ~m_prev;
        if (bus.we && a == A_SWI) set_m = set_m | d[N-1:0];
        clr_m = (bus.we && a == A_PEND) ? d[N-1:0] : '0;
        elig  = m_ctrl ? (m_pend & m_en) : '0;
        if (m_req) begin
            if (bus.int_ack) begin
                m_req = 0; m_busy = 1; clr_m[m_id] = 1'b1;
            end
        end else if (m_busy) begin
            if (bus.int_done) m_busy = 0;
        end else if (elig != '0) begin
            low   = elig & (~elig + 1'b1);
            m_id  = $clog2(low);
            m_pc  = m_vec[m_id];
            m_req = 1;
        end
        m_pend = (m_pend & ~clr_m) | set_m;
        if (bus.we) begin
            if (a == A_CTRL) m_ctrl = d[0];
            if (a == A_EN)   m_en   = d[N-1:0];
            for (int i = 0; i < N; i++) if (a == A_VEC + 32'(4 * i)) m_vec[i] = d;
        end
        m_prev = irq_in;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.data = d;
        cycle();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.re = 1'b1; bus.addr = a;
        cycle();
        bus.re = 1'b0;
        d = bus.rdata;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1; cycle(); bus.int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.int_done = 1'b1; cycle(); bus.int_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", bus.int_req); else n_pass++;
        n_checks++; if (bus.rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus.rdata); else n_pass++;
        n_checks++; if (bus.int_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", bus.int_pc); else n_pass++;
        n_checks++; if (bus.int_id !== 3'd0) $display("FAIL rst_id: got %0d want 0", bus.int_id); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        wr(A_VEC + 32'd8, 32'h1000);
        wr(A_EN, 32'h4);
        wr(A_CTRL, 32'h1);
        irq_in = 4'b0100;
        cycle();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL basic_early: got %0b want 0", bus.int_req); else n_pass++;
        cycle();
        irq_in = 4'b0000;
        n_checks++; if (bus.int_req !== 1'b1) $display("FAIL basic_req: got %0b want 1", bus.int_req); else n_pass++;
        n_checks++; if (bus.int_pc !== 32'h1000) $display("FAIL basic_pc: got %h want 1000", bus.int_pc); else n_pass++;
        n_checks++; if (bus.int_id !== 3'd2) $display("FAIL basic_id: got %0d want 2", bus.int_id); else n_pass++;
        pulse_ack();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL basic_ackdrop: got %0b want 0", bus.int_req); else n_pass++;
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h0) $display("FAIL basic_pend: got %h want 0", d); else n_pass++;
        pulse_done();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL basic_idle: got %0b want 0", bus.int_req); else n_pass++;
    endtask

    task automatic test_priority();
        wr(A_EN, 32'hA);
        wr(A_VEC + 32'd4, 32'h2000);
        wr(A_VEC + 32'd12, 32'h3000);
        irq_in = 4'b1010;
        cycle(); cycle();
        n_checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd1) $display("FAIL prio_first: req %0b id %0d want req 1 id 1", bus.int_req, bus.int_id); else n_pass++;
        n_checks++; if (bus.int_pc !== 32'h2000) $display("FAIL prio_pc1: got %h want 2000", bus.int_pc); else n_pass++;
        pulse_ack();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (bus.int_req !== 1'b0) $display("FAIL prio_blocked: got %0b want 0", bus.int_req); else n_pass++;
        end
        pulse_done();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL prio_at_done: got %0b want 0", bus.int_req); else n_pass++;
        cycle();
        n_checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd3) $display("FAIL prio_second: req %0b id %0d want req 1 id 3", bus.int_req, bus.int_id); else n_pass++;
        n_checks++; if (bus.int_pc !== 32'h3000) $display("FAIL prio_pc3: got %h want 3000", bus.int_pc); else n_pass++;
        pulse_ack();
        pulse_done();
        irq_in = 4'b0000;
        cycle();
    endtask

    task automatic test_ctrl_gate();
        logic [31:0] d;
        wr(A_CTRL, 32'h0);
        wr(A_EN, 32'h1);
        irq_in = 4'b0001;
        cycle(); cycle(); cycle();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL gate_req: got %0b want 0", bus.int_req); else n_pass++;
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h1) $display("FAIL gate_pend: got %h want 1", d); else n_pass++;
        wr(A_CTRL, 32'h1);
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL gate_same: got %0b want 0", bus.int_req); else n_pass++;
        cycle();
        n_checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0) $display("FAIL gate_on: req %0b id %0d want req 1 id 0", bus.int_req, bus.int_id); else n_pass++;
    endtask

    task automatic test_reentry();
        logic [31:0] d;
        pulse_ack();
        irq_in = 4'b0000; cycle();
        irq_in = 4'b0001; cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (bus.int_req !== 1'b0) $display("FAIL reent_blocked: got %0b want 0", bus.int_req); else n_pass++;
        end
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h1) $display("FAIL reent_pend: got %h want 1", d); else n_pass++;
        pulse_done();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL reent_at_done: got %0b want 0", bus.int_req); else n_pass++;
        cycle();
        n_checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0) $display("FAIL reent_again: req %0b id %0d want req 1 id 0", bus.int_req, bus.int_id); else n_pass++;
        pulse_ack();
        pulse_done();
        irq_in = 4'b0000;
        cycle();
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        wr(A_EN, 32'h0);
        irq_in = 4'b0010;
        wr(A_PEND, 32'h2);
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h2) $display("FAIL setwin_pend: got %h want 2", d); else n_pass++;
        wr(A_PEND, 32'h2);
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h0) $display("FAIL w1c_pend: got %h want 0", d); else n_pass++;
        irq_in = 4'b0000;
        wr(A_EN, 32'h8);
        wr(A_SWI, 32'h8);
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL swi_early: got %0b want 0", bus.int_req); else n_pass++;
        cycle();
        n_checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd3) $display("FAIL swi_req: req %0b id %0d want req 1 id 3", bus.int_req, bus.int_id); else n_pass++;
        n_checks++; if (bus.int_pc !== 32'h3000) $display("FAIL swi_pc: got %h want 3000", bus.int_pc); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        logic [31:0] addrs [4];
        addrs[0] = A_CTRL; addrs[1] = A_EN; addrs[2] = A_PEND; addrs[3] = A_VEC + 32'd8;
        reset = 1'b1; cycle(); reset = 1'b0;
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL abort_req: got %0b want 0", bus.int_req); else n_pass++;
        n_checks++; if (bus.int_pc !== 32'h0 || bus.int_id !== 3'd0) $display("FAIL abort_pcid: pc %h id %0d want 0 0", bus.int_pc, bus.int_id); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], d);
            n_checks++; if (d !== 32'h0) $display("FAIL abort_reg%0d: got %h want 0", i, d); else n_pass++;
        end
        pulse_ack();
        pulse_done();
        cycle();
        n_checks++; if (bus.int_req !== 1'b0) $display("FAIL stray_req: got %0b want 0", bus.int_req); else n_pass++;
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h0) $display("FAIL stray_pend: got %h want 0", d); else n_pass++;
    endtask

    function automatic logic [31:0] pick_addr(input int k);
        case (k)
            0:  return A_CTRL;
            1:  return A_EN;
            2:  return A_PEND;
            3:  return A_SWI;
            4:  return A_VEC;
            5:  return A_VEC + 32'd4;
            6:  return A_VEC + 32'd8;
            7:  return A_VEC + 32'd12;
            8:  return A_VEC + 32'd16;
            9:  return A_CTRL + 32'd1;
            default: return 32'h90000000;
        endcase
    endfunction

    task automatic test_random();
        int op;
        for (int i = 0; i < N; i++) wr(A_VEC + 32'(4 * i), $urandom);
        wr(A_EN, 32'hF);
        wr(A_CTRL, 32'h1);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
            bus.int_ack  = ($urandom_range(0, 2) == 0);
            bus.int_done = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 299) == 0);
            op = $urandom_range(0, 9);
            bus.we   = (op == 0);
            bus.re   = (op >= 1 && op <= 3);
            bus.addr = pick_addr($urandom_range(0, 10));
            bus.data = $urandom;
            if (op == 0 && bus.addr == A_CTRL && $urandom_range(0, 3) != 0) bus.data[0] = 1'b1;
            cycle();
            n_checks++; if (bus.int_req !== m_req) $display("FAIL rnd_req c%0d: got %0b want %0b", c, bus.int_req, m_req); else n_pass++;
            if (m_req) begin
                n_checks++; if (bus.int_id !== 3'(m_id)) $display("FAIL rnd_id c%0d: got %0d want %0d", c, bus.int_id, m_id); else n_pass++;
                n_checks++; if (bus.int_pc !== m_pc) $display("FAIL rnd_pc c%0d: got %h want %h", c, bus.int_pc, m_pc); else n_pass++;
            end
            n_checks++; if (bus.rdata !== m_rdata) $display("FAIL rnd_rdata c%0d: got %h want %h", c, bus.rdata, m_rdata); else n_pass++;
        end
        bus.we = 1'b0; bus.re = 1'b0; bus.int_ack = 1'b0; bus.int_done = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.data = '0;
        bus.int_ack = 1'b0; bus.int_done = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_ctrl_gate();
        test_reentry();
        test_set_wins();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
